spi_master_adapter: RTL

Controller-side counterpart of the SPI minion adapter. Accepts payload words from the host over val/rdy and serializes them into SPI frames carrying write-valid and read-request flags. Deserializes the minion's concurrent response frame (valid, space, payload) into a 2-entry receive queue that drains to the host over val/rdy. Sits between the on-chip host/test harness and the SPI pins that drive a minion.

---
 rtl/spi_master_pkg.sv | 17 +
 rtl/spi_master_adapter_if.sv | 26 ++
 rtl/spi_master_adapter_queue.sv | 65 ++++++
 rtl/spi_master_adapter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and frame-layout helpers for the SPI master adapter.
package spi_master_pkg;

  typedef enum logic [1:0] {IDLE, START, SHIFT, END} state_e;

  localparam int RX_DEPTH = 2;

  // Flag positions inside an nbits-wide frame; the TX and RX layouts share them.
  function automatic int bit_wrt(input int nbits);
    return nbits - 1;
  endfunction

  function automatic int bit_rd(input int nbits);
    return nbits - 2;
  endfunction

endpackage

// File: rtl/spi_master_adapter_if.sv
// Host val/rdy streams plus the SPI pin bundle of the master adapter.
interface spi_master_adapter_if #(
  parameter int nbits = 8
);
  logic [nbits-3:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-3:0] send_msg;
  logic             send_val;
  logic             send_rdy;
  logic             poll_en;
  logic             spi_sclk;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;

  modport master (
    input  recv_msg, recv_val, send_rdy, poll_en, spi_miso,
    output recv_rdy, send_msg, send_val, spi_sclk, spi_cs_n, spi_mosi
  );

  modport slave (
    output recv_msg, recv_val, send_rdy, poll_en, spi_miso,
    input  recv_rdy, send_msg, send_val, spi_sclk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_master_adapter_queue.sv
// Small show-ahead FIFO; the head entry is always visible on deq_msg_o.
module vc_Queue #(
  parameter int nbits       = 6,
  parameter int num_entries = 2,
  localparam int CNT_W      = $clog2(num_entries + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val_i,
  input  logic [nbits-1:0] enq_msg_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [nbits-1:0] deq_msg_o,
  output logic [CNT_W-1:0] num_free_entries_o
);
  localparam int PTR_W = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(num_entries - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(num_entries);

  logic [nbits-1:0] mem_q [num_entries];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire;
  logic             deq_fire;

  // A write into a full queue is dropped rather than corrupting the head.
  assign enq_fire = enq_val_i && (count_q != CNT_FULL);
  assign deq_fire = deq_rdy_i && deq_val_o;

  assign deq_val_o          = (count_q != '0);
  assign deq_msg_o          = mem_q[rd_ptr_q];
  assign num_free_entries_o = CNT_FULL - count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    if (enq_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[wr_ptr_q] <= enq_msg_i;
    end
  end

endmodule

// File: rtl/spi_master_adapter.sv
// SPI mode-0 master that frames host writes and read polls for an SPI minion
// adapter and queues the minion's returned payloads for the host.
module spi_master_adapter
  import spi_master_pkg::*;
#(
  parameter int nbits   = 8,
  parameter int clk_div = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_master_adapter_if.master bus
);
  localparam int PW    = nbits - 2;
  localparam int WRT   = bit_wrt(nbits);
  localparam int VAL   = WRT;
  localparam int SPC   = bit_rd(nbits);
  localparam int CNT_W = $clog2(clk_div) + 1;
  localparam int BIT_W = $clog2(2 * nbits);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * nbits - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [nbits-2:0] tx_q;
  logic [nbits-1:0] rx_q;
  logic             frame_wrt_q;
  logic             frame_rd_q;
  logic             spc_ok_q;
  logic             rd_pending_q;
  logic             sclk_q;
  logic             cs_n_q;
  logic             mosi_q;

  logic       recv_rdy;
  logic       hs;
  logic       rd_ok;
  logic       launch;
  logic       tick;
  logic       end_first;
  logic       rx_push;
  logic [1:0] rx_free;

  assign recv_rdy  = reset && (state_q == IDLE) && spc_ok_q;
  assign hs        = bus.recv_val && recv_rdy;
  // Reserve a queue slot for the response of a read already in flight.
  assign rd_ok     = bus.poll_en && (rx_free > {1'b0, rd_pending_q});
  assign launch    = hs || rd_ok || rd_pending_q || !spc_ok_q;
  assign tick      = (cnt_q == CNT_LAST);
  assign cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
  assign end_first = (state_q == END) && (cnt_q == '0);
  assign rx_push   = end_first && rx_q[VAL];

  assign bus.recv_rdy = recv_rdy;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = mosi_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      frame_wrt_q  <= 1'b0;
      frame_rd_q   <= 1'b0;
      spc_ok_q     <= 1'b1;
      rd_pending_q <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            // MSB goes straight to MOSI; tx_q keeps the remaining bits.
            tx_q        <= {rd_ok, hs ? bus.recv_msg : {PW{1'b0}}};
            frame_wrt_q <= hs;
            frame_rd_q  <= rd_ok;
            mosi_q      <= hs;
            cs_n_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (tick) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b1;
            rx_q      <= {rx_q[nbits-2:0], bus.spi_miso};
          end
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          if (tick) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= END;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              if (!bit_cnt_q[0]) begin
                sclk_q <= 1'b0;
                mosi_q <= tx_q[nbits-2];
                tx_q   <= {tx_q[nbits-3:0], 1'b0};
              end else begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[nbits-2:0], bus.spi_miso};
              end
            end
          end
        end
        END: begin
          cnt_q <= cnt_d;
          if (end_first) begin
            rd_pending_q <= frame_rd_q;
            // A write consumes the minion's credit; only a later probe restores it.
            spc_ok_q     <= frame_wrt_q ? 1'b0 : rx_q[SPC];
          end
          if (tick) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vc_Queue #(
    .nbits       (PW),
    .num_entries (RX_DEPTH)
  ) rx_queue (
    .clk                (clk),
    .reset              (reset),
    .enq_val_i          (rx_push),
    .enq_msg_i          (rx_q[PW-1:0]),
    .deq_val_o          (bus.send_val),
    .deq_rdy_i          (bus.send_rdy),
    .deq_msg_o          (bus.send_msg),
    .num_free_entries_o (rx_free)
  );

endmodule
